cnn_layer_sequencer: RTL and testbench

Autonomous layer scheduler for the CNN accelerator. It drives the 8-bit layer-select code into the CNN control block, clears that block's completion status, gates the image-load phase on a host handshake, and walks the fixed sequence conv1 → pool1 → conv2 → pool2 → FC. Each layer advances only when the returned completion code matches the issued layer. The host sees one start/done/irq interface instead of stepping the layers itself over the bus.

---
 rtl/cnn_layer_sequencer.sv | 154 +++++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Layer scheduler for the CNN accelerator: clear, image load, then conv1..FC in order.
// Optional per-layer watchdog and ERR path enabled by defining SEQ_TIMEOUT_EN.
module cnn_layer_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned TO_W           = 21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        img_ready,
    input  logic [7:0]  return_ctrl,
    output logic [7:0]  ctrl,
    output logic        cnn_reset,
    output logic        busy,
    output logic        done,
    output logic        irq,
    output logic        error,
    output logic [2:0]  err_layer,
    output logic [2:0]  layer_idx,
    output logic [31:0] cycle_count,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    // Handshakes: start/abort are one-cycle pulses sampled on clk; img_ready is a
    // level qualified only in LOAD; return_ctrl is compared against the issued
    // layer every RUN cycle and any other code is ignored.

    logic [2:0] state, state_nx;
    logic [2:0] layer, layer_nx;
    logic       clr_cnt, clr_cnt_nx;
    logic       match;
    logic       wd_expired;
    logic       run_start;

    assign match     = (return_ctrl == {5'd0, layer});
    assign run_start = (state == S_IDLE) && (state_nx == S_CLEAR);
    assign state_dbg = state;

    always_comb begin
        state_nx   = state;
        layer_nx   = layer;
        clr_cnt_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                if (abort)        state_nx = S_IDLE;
                else if (clr_cnt) state_nx = S_LOAD;
                else              clr_cnt_nx = 1'b1;
            end
            S_LOAD: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (img_ready) begin
                    state_nx = S_RUN;
                    layer_nx = 3'd1;
                end
            end
            S_RUN: begin
                // A match in the same cycle the watchdog expires still advances.
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (match) begin
                    if (layer == 3'd5) state_nx = S_DONE;
                    else               layer_nx = layer + 3'd1;
                end else if (wd_expired) begin
                    state_nx = S_ERR;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            layer       <= 3'd0;
            clr_cnt     <= 1'b0;
            ctrl        <= 8'd0;
            layer_idx   <= 3'd0;
            cnn_reset   <= 1'b0;
            busy        <= 1'b0;
            irq         <= 1'b0;
            done        <= 1'b0;
            cycle_count <= 32'd0;
        end else begin
            state     <= state_nx;
            layer     <= layer_nx;
            clr_cnt   <= clr_cnt_nx;
            ctrl      <= (state_nx == S_RUN) ? {5'd0, layer_nx} : 8'd0;
            layer_idx <= (state_nx == S_RUN) ? layer_nx : 3'd0;
            cnn_reset <= (state_nx == S_CLEAR);
            busy      <= (state_nx == S_CLEAR) || (state_nx == S_LOAD) || (state_nx == S_RUN);
            irq       <= (state_nx == S_DONE) || (state_nx == S_ERR);

            if (run_start)                done <= 1'b0;
            else if (state_nx == S_DONE)  done <= 1'b1;

            if (run_start)
                cycle_count <= 32'd0;
            else if ((state == S_RUN) && (cycle_count != 32'hFFFF_FFFF))
                cycle_count <= cycle_count + 32'd1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic [TO_W-1:0] wd_cnt;

    assign wd_expired = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts RUN cycles spent on the current layer; restarts on every issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt    <= '0;
            error     <= 1'b0;
            err_layer <= 3'd0;
        end else begin
            if ((state == S_RUN) && (state_nx == S_RUN) && !match)
                wd_cnt <= wd_cnt + TO_W'(1);
            else
                wd_cnt <= '0;

            if (run_start) begin
                error     <= 1'b0;
                err_layer <= 3'd0;
            end else if (state_nx == S_ERR) begin
                error     <= 1'b1;
                err_layer <= layer;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
    assign err_layer  = 3'd0;

    // Watchdog parameters are kept on the interface but have no hardware here.
    if ((TIMEOUT_CYCLES < 2) || (TO_W < 1)) begin : g_unused_watchdog_params
    end
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: CNN control-block model, randomized layer latencies,
// scoreboard of expected run results checked by an independent monitor.
module tb_cnn_layer_sequencer;

    localparam int T_CYC = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        img_ready = 1'b0;
    logic [7:0]  return_ctrl = 8'd0;
    logic [7:0]  ctrl;
    logic        cnn_reset;
    logic        busy;
    logic        done;
    logic        irq;
    logic        error;
    logic [2:0]  err_layer;
    logic [2:0]  layer_idx;
    logic [31:0] cycle_count;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    // Expected run result: {done, error, err_layer, cycle_count}
    logic [36:0] exp_q[$];

    int unsigned lat [1:5];
    int          hang_layer = 0;
    logic        stale_en = 1'b0;
    logic [7:0]  stale_code = 8'd0;

    cnn_layer_sequencer #(
        .TIMEOUT_CYCLES(T_CYC),
        .TO_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .img_ready(img_ready),
        .return_ctrl(return_ctrl),
        .ctrl(ctrl),
        .cnn_reset(cnn_reset),
        .busy(busy),
        .done(done),
        .irq(irq),
        .error(error),
        .err_layer(err_layer),
        .layer_idx(layer_idx),
        .cycle_count(cycle_count),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not end, bad=%0d", bad);
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- CNN control block model ----------------
    // Returns code k exactly lat[k] cycles after it first sees ctrl=k; cnn_reset clears it.
    logic [7:0] seen = 8'd0;
    int         cnt = 0;
    always @(negedge clk) begin
        if (!reset || cnn_reset) begin
            return_ctrl = 8'd0;
            seen = 8'd0;
            cnt = 0;
        end else if (!busy) begin
            if (stale_en) return_ctrl = stale_code;
            seen = 8'd0;
            cnt = 0;
        end else if (ctrl != seen) begin
            seen = ctrl;
            cnt = 0;
        end else begin
            cnt++;
        end
        if (reset && busy && ctrl != 8'd0 && ctrl <= 8'd5 && ctrl == seen &&
            cnt == int'(lat[int'(ctrl)]) && int'(ctrl) != hang_layer)
            return_ctrl = ctrl;
    end

    // ---------------- monitor / scoreboard ----------------
    logic [7:0]  ctrl_b;
    logic [7:0]  rc_s;
    logic        prev_irq = 1'b0;
    logic [36:0] got;
    logic [36:0] want;
    always begin
        @(posedge clk);
        rc_s   = return_ctrl;
        ctrl_b = ctrl;
        #1;
        if (reset) begin
            if (ctrl != ctrl_b && ctrl != 8'd0) begin
                check("ctrl_step", 64'(ctrl), 64'(ctrl_b + 8'd1));
                if (ctrl_b != 8'd0) check("advance_on_match", 64'(rc_s), 64'(ctrl_b));
            end
            if (irq) begin
                check("irq_width", 64'(prev_irq), 64'd0);
                check("irq_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    got  = {done, error, err_layer, cycle_count};
                    want = exp_q.pop_front();
                    check("run_result", 64'(got), 64'(want));
                end
                check("ctrl_at_irq", 64'(ctrl), 64'd0);
                check("busy_at_irq", 64'(busy), 64'd0);
                check("layer_idx_at_irq", 64'(layer_idx), 64'd0);
            end
            prev_irq = irq;
        end else begin
            prev_irq = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, 64'(ctrl), 64'd0);
        check({tag, "_cnn_reset"}, 64'(cnn_reset), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_irq"}, 64'(irq), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_err_layer"}, 64'(err_layer), 64'd0);
        check({tag, "_layer_idx"}, 64'(layer_idx), 64'd0);
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    endtask

    task automatic start_and_check_clear();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_t1", 64'(busy), 64'd1);
        check("cnn_reset_t1", 64'(cnn_reset), 64'd1);
        check("done_cleared", 64'(done), 64'd0);
        check("error_cleared", 64'(error), 64'd0);
        check("cc_cleared", 64'(cycle_count), 64'd0);
        @(negedge clk);
        check("cnn_reset_t2", 64'(cnn_reset), 64'd1);
        check("ctrl_in_clear", 64'(ctrl), 64'd0);
        @(negedge clk);
        check("cnn_reset_t3", 64'(cnn_reset), 64'd0);
        check("busy_t3", 64'(busy), 64'd1);
    endtask

    task automatic wait_ctrl(input logic [7:0] k, input int max);
        int n = 0;
        while (ctrl != k && n < max) begin
            @(negedge clk);
            n++;
        end
        check("reach_ctrl", 64'(ctrl), 64'(k));
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("run_finishes", 64'(busy), 64'd0);
    endtask

    task automatic set_lat_all(input int unsigned v);
        for (int k = 1; k <= 5; k++) lat[k] = v;
    endtask

    task automatic set_lat_random();
        for (int k = 1; k <= 5; k++) lat[k] = $urandom_range(0, 12);
    endtask

    // Full run: each layer occupies (latency + 1) RUN cycles.
    task automatic run_once(input int unsigned rdy_delay, input bit collide);
        int unsigned cc = 0;
        for (int k = 1; k <= 5; k++) cc += lat[k] + 1;
        exp_q.push_back({1'b1, 1'b0, 3'd0, 32'(cc)});
        img_ready = 1'b0;
        start_and_check_clear();
        repeat (rdy_delay) @(negedge clk);
        img_ready = 1'b1;
        if (collide) begin
            wait_ctrl(8'd2, 200);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("start_busy_ignored_busy", 64'(busy), 64'd1);
            check("start_busy_ignored_clear", 64'(cnn_reset), 64'd0);
        end
        wait_idle(1000);
        img_ready = 1'b0;
        @(negedge clk);
        check("irq_drop", 64'(irq), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned cc_abort;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Nominal: image ready 10 cycles after start, 20-cycle layer latency.
        set_lat_all(20);
        run_once(10, 1'b0);
        check("nominal_done", 64'(done), 64'd1);

        // Stale completion codes left on return_ctrl before start.
        for (int s = 0; s < 2; s++) begin
            stale_code = (s == 0) ? 8'd3 : 8'd1;
            stale_en = 1'b1;
            repeat (3) @(negedge clk);
            set_lat_random();
            run_once($urandom_range(0, 8), 1'b0);
            stale_en = 1'b0;
        end

        // Start pulse while busy must not disturb the run.
        set_lat_all(6);
        run_once(2, 1'b1);

        // Randomized runs.
        for (int r = 0; r < 4; r++) begin
            set_lat_random();
            run_once($urandom_range(0, 8), 1'b0);
        end

        // Abort during layer 3, then a clean run.
        set_lat_all(20);
        img_ready = 1'b0;
        start_and_check_clear();
        img_ready = 1'b1;
        wait_ctrl(8'd3, 500);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctrl", 64'(ctrl), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_irq", 64'(irq), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_error", 64'(error), 64'd0);
        check("abort_cnn_reset", 64'(cnn_reset), 64'd0);
        cc_abort = (lat[1] + 1) + (lat[2] + 1) + 1;
        check("abort_cycle_count", 64'(cycle_count), 64'(cc_abort));
        img_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_cc_held", 64'(cycle_count), 64'(cc_abort));
        set_lat_random();
        run_once(3, 1'b0);

        // start and abort together in IDLE: no run, done stays from the last run.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_cnn_reset", 64'(cnn_reset), 64'd0);
        check("start_abort_done_kept", 64'(done), 64'd1);
        repeat (3) @(negedge clk);
        check("start_abort_still_idle", 64'(busy), 64'd0);

`ifdef SEQ_TIMEOUT_EN
        // Layer 2 never completes: watchdog fires after T_CYC cycles on it.
        set_lat_random();
        hang_layer = 2;
        exp_q.push_back({1'b0, 1'b1, 3'd2, 32'(lat[1] + 1 + T_CYC)});
        img_ready = 1'b0;
        start_and_check_clear();
        img_ready = 1'b1;
        wait_idle(1000);
        img_ready = 1'b0;
        hang_layer = 0;
        @(negedge clk);
        check("timeout_irq_drop", 64'(irq), 64'd0);
        check("timeout_error_sticky", 64'(error), 64'd1);
        check("timeout_err_layer", 64'(err_layer), 64'd2);
        check("timeout_ctrl", 64'(ctrl), 64'd0);
`else
        check("no_watchdog_error", 64'(error), 64'd0);
        check("no_watchdog_err_layer", 64'(err_layer), 64'd0);
`endif

        // Asynchronous reset during layer 4.
        set_lat_all(8);
        img_ready = 1'b0;
        start_and_check_clear();
        img_ready = 1'b1;
        wait_ctrl(8'd4, 500);
        #2 reset = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        img_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        set_lat_random();
        run_once(1, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
